// File: rtl/pipe_stall_if.sv
// pipe_stall_if: ID/EX hazard inputs and interlock outputs between pipeline and pipe_stall_ctrl
interface pipe_stall_if;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       uses_rs_id;
  logic       uses_rt_id;
  logic [4:0] dst_ex;
  logic       memread_ex;
  logic       regwrite_ex;
  logic       branch_taken_ex;
  logic       md_start_ex;
  logic       md_uses_hilo_id;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       flush_id;
  logic       md_busy;
  logic       md_done;
  modport master (
    output rs_id, rt_id, uses_rs_id, uses_rt_id, dst_ex, memread_ex, regwrite_ex,
           branch_taken_ex, md_start_ex, md_uses_hilo_id,
    input  stall_if, stall_id, bubble_ex, flush_id, md_busy, md_done
  );
  modport slave (
    input  rs_id, rt_id, uses_rs_id, uses_rt_id, dst_ex, memread_ex, regwrite_ex,
           branch_taken_ex, md_start_ex, md_uses_hilo_id,
    output stall_if, stall_id, bubble_ex, flush_id, md_busy, md_done
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: load-use / HI-LO interlock and branch flush; mul/div busy FSM built only with MULDIV_INTERLOCK_EN
module pipe_stall_ctrl #(
  parameter int MD_LATENCY = 32
) (
  input logic          clk,
  input logic          rst,
  pipe_stall_if.slave  p
);
  logic lu, md_hz, stl;
  assign lu = p.memread_ex & p.regwrite_ex & (p.dst_ex != 5'd0) &
              ((p.uses_rs_id & (p.rs_id == p.dst_ex)) | (p.uses_rt_id & (p.rt_id == p.dst_ex)));
`ifdef MULDIV_INTERLOCK_EN
  localparam int CW = $clog2(MD_LATENCY);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      p.md_busy <= 1'b0;
      p.md_done <= 1'b0;
    end else if (state == IDLE) begin
      p.md_done <= 1'b0;
      if (p.md_start_ex) begin
        state     <= BUSY;
        cnt       <= CW'(MD_LATENCY - 1);
        p.md_busy <= 1'b1;
      end
    end else if (cnt == '0) begin
      state     <= IDLE;
      p.md_busy <= 1'b0;
      p.md_done <= 1'b0;
    end else begin
      cnt       <= cnt - 1'b1;
      p.md_done <= (cnt == CW'(1));
    end
  // a mult/div in ID stalls while busy, so a start here means the pipeline is broken
  assert property (@(posedge clk) disable iff (rst) !(p.md_start_ex && state == BUSY))
    else $error("md_start_ex while multiply/divide busy");
  assign md_hz = p.md_busy & p.md_uses_hilo_id;
`else
  logic unused_md;
  assign unused_md = p.md_start_ex ^ p.md_uses_hilo_id ^ clk ^ rst;
  assign p.md_busy = 1'b0;
  assign p.md_done = 1'b0;
  assign md_hz     = 1'b0;
`endif
  assign stl         = lu | md_hz;
  assign p.flush_id  = p.branch_taken_ex;
  assign p.bubble_ex = stl | p.branch_taken_ex;
  assign p.stall_if  = stl & ~p.branch_taken_ex;
  assign p.stall_id  = stl & ~p.branch_taken_ex;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of pipe_stall_ctrl with MD_LATENCY=4, both macro settings
module tb_pipe_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  pipe_stall_if bus ();
  pipe_stall_ctrl #(.MD_LATENCY(4)) dut (.clk(clk), .rst(rst), .p(bus));
  always #5 clk = ~clk;
  // {stall_if, stall_id, bubble_ex, flush_id, md_busy, md_done}
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.flush_id, bus.md_busy, bus.md_done};
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.rs_id = 5'd0; bus.rt_id = 5'd0; bus.uses_rs_id = 1'b0; bus.uses_rt_id = 1'b0;
    bus.dst_ex = 5'd0; bus.memread_ex = 1'b0; bus.regwrite_ex = 1'b0;
    bus.branch_taken_ex = 1'b0; bus.md_start_ex = 1'b0; bus.md_uses_hilo_id = 1'b0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1 idle();
  endtask
  task automatic lu_rs();
    bus.memread_ex = 1'b1; bus.regwrite_ex = 1'b1; bus.dst_ex = 5'd5;
    bus.rs_id = 5'd5; bus.uses_rs_id = 1'b1;
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #3 chk("reset", 6'b000000);
    cyc(); rst = 1'b0;
    #3 chk("idle_after_reset", 6'b000000);
    cyc(); lu_rs();
    #3 chk("lu_rs", 6'b111000);
    cyc(); lu_rs(); bus.memread_ex = 1'b0;
    #3 chk("lu_cleared", 6'b000000);
    cyc(); lu_rs(); bus.dst_ex = 5'd0; bus.rs_id = 5'd0;
    #3 chk("lu_dst_zero", 6'b000000);
    cyc(); lu_rs(); bus.uses_rs_id = 1'b0;
    #3 chk("lu_rs_unused", 6'b000000);
    cyc(); bus.memread_ex = 1'b1; bus.regwrite_ex = 1'b1; bus.dst_ex = 5'd7;
    bus.rt_id = 5'd7; bus.uses_rt_id = 1'b1; bus.rs_id = 5'd3; bus.uses_rs_id = 1'b1;
    #3 chk("lu_rt", 6'b111000);
    cyc(); lu_rs(); bus.regwrite_ex = 1'b0;
    #3 chk("lu_no_regwrite", 6'b000000);
    cyc(); lu_rs(); bus.branch_taken_ex = 1'b1;
    #3 chk("flush_beats_stall", 6'b001100);
    cyc(); bus.branch_taken_ex = 1'b1;
    #3 chk("flush_alone", 6'b001100);
`ifdef MULDIV_INTERLOCK_EN
    cyc(); bus.md_start_ex = 1'b1; bus.md_uses_hilo_id = 1'b1;
    #3 chk("md_c0", 6'b000000);
    for (int c = 1; c <= 4; c++) begin
      cyc(); bus.md_uses_hilo_id = 1'b1;
      #3 chk($sformatf("md_c%0d", c), (c == 4) ? 6'b111011 : 6'b111010);
    end
    cyc(); bus.md_uses_hilo_id = 1'b1; bus.md_start_ex = 1'b1;
    #3 chk("md_c5_released", 6'b000000);
    cyc();
    #3 chk("md_c6_no_hilo", 6'b000010);
    cyc(); bus.branch_taken_ex = 1'b1;
    #3 chk("md_c7_branch", 6'b001110);
    cyc(); bus.md_uses_hilo_id = 1'b1;
    #3 chk("md_c8_hilo", 6'b111010);
    cyc();
    #3 chk("md_c9_done", 6'b000011);
    cyc();
    #3 chk("md_c10_idle", 6'b000000);
    cyc(); bus.md_start_ex = 1'b1;
    #3 chk("md_restart", 6'b000000);
    cyc();
    #3 chk("md_busy_before_rst", 6'b000010);
    #1 rst = 1'b1;
    #1 chk("md_async_rst", 6'b000000);
    cyc(); rst = 1'b0;
    cyc();
    #3 chk("md_idle_after_rst", 6'b000000);
`else
    cyc(); bus.md_start_ex = 1'b1; bus.md_uses_hilo_id = 1'b1;
    #3 chk("off_start", 6'b000000);
    for (int c = 1; c <= 4; c++) begin
      cyc(); bus.md_uses_hilo_id = 1'b1;
      #3 chk($sformatf("off_c%0d", c), 6'b000000);
    end
    cyc(); lu_rs(); bus.md_uses_hilo_id = 1'b1;
    #3 chk("off_lu_only", 6'b111000);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
